// File: rtl/garip_sifreleme.sv
// Serial word scrambler: captures a word, applies one of eight reversible transforms, then shifts it out LSB first.
// Optional macro GARIP_SIFRELEME_PARITY_EN appends an even-parity bit after the last data bit.
module garip_sifreleme #(
    parameter int BIT = 4
) (
    input  logic           saat,
    input  logic           reset,
    input  logic           basla,
    input  logic           mod,
    input  logic [BIT-1:0] veri,
    input  logic [2:0]     secim,
    output logic           bit_cikisi,
    output logic           gecerli
);

    if (BIT < 2 || BIT > 32 || (BIT % 2) != 0) begin : g_bit_hata
        $error("garip_sifreleme: BIT must be an even value in 2..32");
    end

`ifdef GARIP_SIFRELEME_PARITY_EN
    localparam int GONDER_CYC = BIT + 1;
`else
    localparam int GONDER_CYC = BIT;
`endif

    localparam int             CW    = $clog2(BIT + 2);
    localparam logic [CW-1:0]  SON   = CW'(GONDER_CYC - 1);
    localparam int             YARIM = BIT / 2;
    localparam logic [BIT-1:0] DESEN = {(BIT / 2){2'b01}};

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        HESAPLA = 2'd1,
        GONDER  = 2'd2
    } durum_t;

    durum_t           r_durum;
    durum_t           w_sonraki;

    logic [BIT-1:0]   r_veri;
    logic             r_mod;
    logic [2:0]       r_secim;
    logic [BIT-1:0]   r_kaydir;
    logic [CW-1:0]    r_sayac;
    logic             r_gecerli;
    logic             r_bit;
`ifdef GARIP_SIFRELEME_PARITY_EN
    logic             r_parite;
`endif

    logic [2*BIT-1:0] w_cift;
    logic [BIT-1:0]   w_ters;
    logic [BIT-1:0]   w_gray_bin;
    logic [BIT-1:0]   w_sonuc;

    // ------------------------------------------------------------------
    // State register and next-state logic
    // ------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge saat or negedge reset) begin
        if (!reset) begin
            r_durum <= IDLE;
        end else begin
            r_durum <= w_sonraki;
        end
    end

    // NOTE: each always_comb output gets a default first so no latch can be inferred.
    always_comb begin
        w_sonraki = r_durum;
        unique case (r_durum)
            IDLE:    if (basla) w_sonraki = HESAPLA;
            HESAPLA: w_sonraki = GONDER;
            GONDER:  if (r_sayac == SON) w_sonraki = IDLE;
            default: w_sonraki = IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Transform datapath, evaluated on the captured word
    // ------------------------------------------------------------------
    assign w_cift = {r_veri, r_veri};

    always_comb begin
        logic acc;
        w_ters     = '0;
        w_gray_bin = '0;
        acc        = 1'b0;
        for (int i = 0; i < BIT; i++) begin
            w_ters[i] = r_veri[BIT-1-i];
        end
        // Gray-to-binary: each binary bit is the XOR of all Gray bits at or above it.
        for (int i = BIT - 1; i >= 0; i--) begin
            acc           = acc ^ r_veri[i];
            w_gray_bin[i] = acc;
        end
    end

    always_comb begin
        w_sonuc = r_veri;
        unique case (r_secim)
            3'd0: w_sonuc = r_veri;
            3'd1: w_sonuc = w_ters;
            3'd2: w_sonuc = r_mod ? w_cift[2*BIT-2 -: BIT] : w_cift[1 +: BIT];
            3'd3: w_sonuc = r_mod ? w_cift[2*BIT-1-YARIM -: BIT] : w_cift[YARIM +: BIT];
            3'd4: w_sonuc = r_veri ^ DESEN;
            3'd5: w_sonuc = r_mod ? (r_veri ^ (r_veri >> 1)) : w_gray_bin;
            3'd6: w_sonuc = r_mod ? (r_veri + BIT'(3)) : (r_veri - BIT'(3));
            3'd7: w_sonuc = ~r_veri;
            default: w_sonuc = r_veri;
        endcase
    end

    // ------------------------------------------------------------------
    // Capture, shift-out and registered serial outputs
    // ------------------------------------------------------------------
    // NOTE: capture and shift registers are reset too, so an aborted result can never reappear.
    always_ff @(posedge saat or negedge reset) begin
        if (!reset) begin
            r_veri    <= '0;
            r_mod     <= 1'b0;
            r_secim   <= '0;
            r_kaydir  <= '0;
            r_sayac   <= '0;
            r_gecerli <= 1'b0;
            r_bit     <= 1'b0;
`ifdef GARIP_SIFRELEME_PARITY_EN
            r_parite  <= 1'b0;
`endif
        end else begin
            r_gecerli <= 1'b0;
            r_bit     <= 1'b0;
            unique case (r_durum)
                IDLE: begin
                    if (basla) begin
                        r_veri  <= veri;
                        r_mod   <= mod;
                        r_secim <= secim;
                    end
                end
                HESAPLA: begin
                    r_kaydir <= w_sonuc;
                    r_sayac  <= '0;
`ifdef GARIP_SIFRELEME_PARITY_EN
                    r_parite <= ^w_sonuc;
`endif
                end
                GONDER: begin
                    // Outputs are registered, so each bit appears one edge after its GONDER cycle.
                    r_gecerli <= 1'b1;
`ifdef GARIP_SIFRELEME_PARITY_EN
                    r_bit     <= (r_sayac == CW'(BIT)) ? r_parite : r_kaydir[0];
`else
                    r_bit     <= r_kaydir[0];
`endif
                    r_kaydir  <= r_kaydir >> 1;
                    r_sayac   <= r_sayac + CW'(1);
                end
                default: ;
            endcase
        end
    end

    assign gecerli    = r_gecerli;
    assign bit_cikisi = r_bit;

endmodule

// File: tb/tb_garip_sifreleme.sv
// Scoreboard bench for garip_sifreleme (BIT=4, parity disabled): stimulus queues expected words,
// a negedge monitor reassembles the serial stream and compares.
module tb_garip_sifreleme;

    localparam int BIT = 4;

    logic           saat;
    logic           reset;
    logic           basla;
    logic           mod;
    logic [BIT-1:0] veri;
    logic [2:0]     secim;
    logic           bit_cikisi;
    logic           gecerli;

    int n_checks = 0;
    int n_errors = 0;

    logic [BIT-1:0] exp_q[$];

    garip_sifreleme #(.BIT(BIT)) dut (
        .saat       (saat),
        .reset      (reset),
        .basla      (basla),
        .mod        (mod),
        .veri       (veri),
        .secim      (secim),
        .bit_cikisi (bit_cikisi),
        .gecerli    (gecerli)
    );

    initial saat = 1'b0;
    always #5 saat = ~saat;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: rebuilds each serial word and compares it with the head of the queue.
    initial begin
        int             nb;
        logic [BIT-1:0] got;
        logic           prev;
        nb   = 0;
        got  = '0;
        prev = 1'b0;
        forever begin
            @(negedge saat);
            if (!reset) begin
                nb   = 0;
                got  = '0;
                prev = 1'b0;
            end else begin
                if (gecerli) begin
                    if (exp_q.size() == 0) begin
                        n_checks++;
                        n_errors++;
                        $display("FAIL spurious_valid: got gecerli=1 expected 0 at %0t", $time);
                    end else if (nb < BIT) begin
                        check($sformatf("bit%0d", nb), 32'(bit_cikisi), 32'(exp_q[0][nb]));
                        got[nb] = bit_cikisi;
                        nb++;
                    end else begin
                        nb++;
                    end
                end else begin
                    check("idle_bit_zero", 32'(bit_cikisi), 32'd0);
                    if (prev && exp_q.size() != 0) begin
                        check("nbits", 32'(nb), 32'(BIT));
                        check("word", 32'(got), 32'(exp_q[0]));
                        void'(exp_q.pop_front());
                    end
                    nb  = 0;
                    got = '0;
                end
                prev = gecerli;
            end
        end
    end

    // One operation with cycle-exact latency checks on gecerli.
    task automatic run_op(input logic m, input logic [BIT-1:0] v, input logic [2:0] s,
                          input logic [BIT-1:0] exp);
        @(negedge saat);
        mod   = m;
        veri  = v;
        secim = s;
        basla = 1'b1;
        exp_q.push_back(exp);
        @(negedge saat);
        basla = 1'b0;
        mod   = ~m;
        veri  = ~v;
        secim = s + 3'd1;
        check("lat_edge1", 32'(gecerli), 32'd0);
        @(negedge saat);
        check("lat_edge2", 32'(gecerli), 32'd0);
        for (int i = 0; i < BIT; i++) begin
            @(negedge saat);
            check($sformatf("valid_cycle%0d", i), 32'(gecerli), 32'd1);
        end
        @(negedge saat);
        check("valid_drop", 32'(gecerli), 32'd0);
    endtask

    task automatic reset_pulse();
        @(negedge saat);
        #2 reset = 1'b0;
        #1;
        check("rst_gecerli", 32'(gecerli), 32'd0);
        check("rst_bit", 32'(bit_cikisi), 32'd0);
        @(negedge saat);
        #2 reset = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int k;
        reset = 1'b0;
        basla = 1'b0;
        mod   = 1'b0;
        veri  = '0;
        secim = '0;
        repeat (2) @(negedge saat);
        check("reset_gecerli", 32'(gecerli), 32'd0);
        check("reset_bit", 32'(bit_cikisi), 32'd0);
        #2 reset = 1'b1;

        // Directed vectors, BIT=4
        run_op(1'b1, 4'd13, 3'd6, 4'd0);   // 13+3 wraps to 0
        reset_pulse();
        run_op(1'b1, 4'd11, 3'd7, 4'd4);   // ~1011 = 0100, LSB first 0,0,1,0
        run_op(1'b0, 4'd6,  3'd3, 4'd9);   // 0110 rotr 2 = 1001
        run_op(1'b1, 4'd9,  3'd2, 4'd3);   // 1001 rotl 1 = 0011
        run_op(1'b0, 4'd3,  3'd2, 4'd9);   // 0011 rotr 1 = 1001
        run_op(1'b1, 4'd1,  3'd1, 4'd8);   // reverse 0001 = 1000
        run_op(1'b0, 4'd6,  3'd4, 4'd3);   // 0110 ^ 0101 = 0011
        run_op(1'b1, 4'd6,  3'd5, 4'd5);   // Gray(0110) = 0101
        run_op(1'b0, 4'd5,  3'd5, 4'd6);   // bin(Gray 0101) = 0110
        run_op(1'b0, 4'd1,  3'd6, 4'd14);  // 1-3 wraps to 14
        run_op(1'b0, 4'd12, 3'd0, 4'd12);  // pass-through

        // Reset during the second output bit aborts the word
        @(negedge saat);
        mod   = 1'b1;
        veri  = 4'd0;
        secim = 3'd7;
        basla = 1'b1;
        exp_q.push_back(4'd15);
        @(negedge saat);
        basla = 1'b0;
        repeat (3) @(negedge saat);
        check("abort_bit1_valid", 32'(gecerli), 32'd1);
        #2 reset = 1'b0;
        exp_q.delete();
        #1;
        check("abort_gecerli", 32'(gecerli), 32'd0);
        check("abort_bit", 32'(bit_cikisi), 32'd0);
        @(negedge saat);
        #2 reset = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge saat);
            check("abort_no_more", 32'(gecerli), 32'd0);
        end

        // basla held high: one result per IDLE entry, mid-operation input changes ignored
        @(negedge saat);
        mod   = 1'b1;
        veri  = 4'd5;
        secim = 3'd0;
        basla = 1'b1;
        exp_q.push_back(4'd5);
        exp_q.push_back(4'd10);
        @(negedge saat);
        @(negedge saat);
        veri = 4'd10;
        repeat (5) @(negedge saat);
        basla = 1'b0;
        veri  = 4'd7;

        k = 0;
        while ((exp_q.size() != 0 || gecerli) && k < 50) begin
            @(negedge saat);
            k++;
        end
        check("drain_queue_empty", 32'(exp_q.size()), 32'd0);
        for (int i = 0; i < 12; i++) begin
            @(negedge saat);
            check("final_idle", 32'(gecerli), 32'd0);
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/garip_sifreleme.md
GARIP_SIFRELEME -- requirements
Module: garip_sifreleme

Interface
REQ-001 BIT  default 4  data width in bits; legal range 2..32, even values only.
REQ-002 saat  input  1  single clock; all state changes on its rising edge.
REQ-003 reset  input  1  asynchronous, active-low reset.
REQ-004 basla  input  1  start strobe; sampled only in IDLE.
REQ-005 mod  input  1  1 = encrypt, 0 = decrypt; sampled with basla.
REQ-006 veri  input  BIT  plaintext/ciphertext word; sampled with basla.
REQ-007 secim  input  3  operation select; sampled with basla.
REQ-008 bit_cikisi  output  1  serial result bit, LSB first.
REQ-009 gecerli  output  1  high while bit_cikisi carries a valid result bit.

Function
REQ-010 FSM SHALL have three states: IDLE, HESAPLA (compute, 1 cycle) and GONDER (shift-out, BIT cycles).
REQ-011 IDLE with basla=1 at an edge SHALL capture veri, mod and secim, then go to HESAPLA.
REQ-012 HESAPLA SHALL compute the result word into a BIT-wide shift register, then go to GONDER.
REQ-013 GONDER SHALL hold gecerli=1 for exactly BIT cycles and present result bit i in the i-th cycle (i=0 first); it SHALL return to IDLE after the last bit.
REQ-014 Latency: if basla is sampled at edge N, gecerli and bit 0 SHALL appear after edge N+2 and gecerli SHALL drop after edge N+2+BIT.
REQ-015 When gecerli=0, bit_cikisi SHALL be 0.
REQ-016 basla SHALL be ignored in HESAPLA and GONDER; inputs changing mid-operation SHALL have no effect.
REQ-017 A back-to-back basla sampled in the first IDLE cycle SHALL start a new operation normally.
REQ-018 Operations, where v is the captured veri and all arithmetic is modulo 2^BIT:
 - secim 0: pass v unchanged.
 - secim 1: bit-reverse v.
 - secim 2: rotate v by 1 (mod=1 left, mod=0 right).
 - secim 3: rotate v by BIT/2 (mod=1 left, mod=0 right).
 - secim 4: v XOR alternating pattern ...0101 (LSB=1).
 - secim 5: mod=1 binary-to-Gray, mod=0 Gray-to-binary.
 - secim 6: mod=1 v+3, mod=0 v-3, with wrap-around.
 - secim 7: bitwise NOT of v.
REQ-019 For every secim, the decrypt operation (mod=0) SHALL invert the encrypt operation (mod=1).

Reset
REQ-020 reset=0 SHALL immediately force IDLE, gecerli=0, bit_cikisi=0 and clear the shift and capture registers, including mid-operation; the aborted result SHALL never be emitted.
REQ-021 After reset deasserts, the first edge with basla=1 SHALL start an operation normally.

Configuration
REQ-022 Macro GARIP_SIFRELEME_PARITY_EN:
 - When defined: GONDER SHALL last BIT+1 cycles, and the extra final cycle SHALL output the even-parity bit (XOR of all result bits) with gecerli=1.
 - When undefined: no parity cycle; behaviour is exactly REQ-013.

Verification
REQ-023 The bench SHALL cover these scenarios (BIT=4, parity macro undefined):
 - mod=1, veri=13, secim=6 -> serial word 0 (wrap), then gecerli=0 after 4 bits.
 - Reset pulse, then mod=1, veri=11, secim=7 -> first bit 0, second bit 0, word 4, then gecerli=0.
 - mod=0, veri=6, secim=3 -> word 9, then gecerli=0.
 - mod=1, veri=9, secim=2 -> word 3; then mod=0, veri=3, secim=2 -> word 9.
 - reset=0 asserted during the second bit of GONDER -> gecerli=0 and bit_cikisi=0 immediately, no further bits.
 - basla=1 held through an operation -> exactly one result per IDLE entry; busy-time strobes have no effect.
